// File: rtl/unsigned_seq_divider_16by8.sv
// Radix-2 restoring divider: 2W-bit dividend by W-bit divisor.
// One quotient bit per cycle, valid/ready on both sides.
module unsigned_seq_divider_16by8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] z,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] x,
    output logic [W-1:0]   r,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*W+1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [2*W-1:0] dvd;
    logic [2*W-1:0] quo;
    logic [W:0]     rem;
    logic [W-1:0]   ys;
    logic [CW-1:0]  cnt;

    logic [W:0]     rem_sh;
    logic           ge;
    logic [W:0]     rem_nx;
    logic [2*W-1:0] quo_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // rem stays below y, so the W+1-bit shifted value never overflows
    always_comb begin
        rem_sh = {rem[W-1:0], dvd[2*W-1]};
        ge     = (rem_sh >= {1'b0, ys});
        rem_nx = ge ? (rem_sh - {1'b0, ys}) : rem_sh;
        quo_nx = {quo[2*W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            quo         <= '0;
            rem         <= '0;
            ys          <= '0;
            cnt         <= '0;
            x           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd <= z;
                        ys  <= y;
                        quo <= '0;
                        rem <= '0;
                        if (y != '0) begin
                            cnt   <= CW'(2*W);
                            state <= RUN;
                        end else begin
                            x           <= '1;
                            r           <= z[W-1:0];
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[2*W-2:0], 1'b0};
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        x           <= quo_nx;
                        r           <= rem_nx[W-1:0];
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
